// File: rtl/data_select_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// data_select_sequencer_pkg
// Shared constants for the instruction sequencer and any other controller
// that reuses the switch decoder.
//   - instruction class codes and minor opcode fields
//   - FSM state encoding and one-hot phase bit positions
//   - mux-select (sw) bit positions
//   - phase_of(): state -> one-hot phase vector
// ---------------------------------------------------------------------------
package data_select_sequencer_pkg;

   // Instruction class, taken from the two MSBs of the instruction word
   localparam logic [1:0] CLS_LOAD  = 2'b00;
   localparam logic [1:0] CLS_STORE = 2'b01;
   localparam logic [1:0] CLS_BR    = 2'b10;  // LI / B / Bcc
   localparam logic [1:0] CLS_SYS   = 2'b11;  // OUT / HLT / misc

   // Minor codes
   localparam logic [3:0] OP_OUT   = 4'b1100;  // op[7:4]
   localparam logic [3:0] OP_HLT   = 4'b1111;  // op[7:4]
   localparam logic [2:0] BCC_COND = 3'b111;   // op[13:11], decoded like any branch

   // FSM state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   // One-hot phase bit positions
   localparam int PH_DECODE = 0;
   localparam int PH_EXEC   = 1;
   localparam int PH_MEM    = 2;
   localparam int PH_WB     = 3;

   // Mux-select bit positions (bit0 = switch1)
   localparam int SW_1 = 0;
   localparam int SW_2 = 1;
   localparam int SW_3 = 2;
   localparam int SW_4 = 3;  // output port select (OUT)
   localparam int SW_5 = 4;
   localparam int SW_6 = 5;  // store data path

   // One-hot phase for a given state; IDLE and HALT show no phase.
   function automatic logic [3:0] phase_of(input logic [2:0] st);
      logic [3:0] ph;
      ph = 4'b0000;
      case (st)
         ST_DECODE: ph[PH_DECODE] = 1'b1;
         ST_EXEC:   ph[PH_EXEC]   = 1'b1;
         ST_MEM:    ph[PH_MEM]    = 1'b1;
         ST_WB:     ph[PH_WB]     = 1'b1;
         default:   ph = 4'b0000;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/data_select_sequencer_sw_decode.sv
// ---------------------------------------------------------------------------
// data_select_sequencer_sw_decode
// Purely combinational instruction -> mux-select decoder.
//   op      in   OP_W   instruction word
//   sw      out  N_SW   decoded mux selects (bits above 5 always 0)
//   is_hlt  out  1      instruction is HLT
//   is_mem  out  1      instruction needs a MEM phase (load/store)
// ---------------------------------------------------------------------------
module data_select_sequencer_sw_decode
   import data_select_sequencer_pkg::*;
#(
   parameter int OP_W = 16,
   parameter int N_SW = 6
) (
   input  logic [OP_W-1:0] op,
   output logic [N_SW-1:0] sw,
   output logic            is_hlt,
   output logic            is_mem
);

   logic [1:0] cls;
   logic [3:0] minor;

   assign cls   = op[OP_W-1:OP_W-2];
   assign minor = op[7:4];

   // Remaining fields carry operands and do not influence mux selection;
   // Bcc (op[13:11] == BCC_COND) decodes exactly like the other branches.
   logic unused_fields;
   assign unused_fields = ^{op[OP_W-3:8], op[3:0]};

   always_comb begin
      sw     = '0;
      is_hlt = 1'b0;
      is_mem = 1'b0;
      case (cls)
         CLS_SYS: begin
            if (minor == OP_OUT) sw[SW_4] = 1'b1;
            is_hlt = (minor == OP_HLT);
         end
         CLS_BR: begin
            sw[SW_1] = 1'b1;
            sw[SW_2] = 1'b1;
            sw[SW_3] = 1'b1;
            sw[SW_5] = 1'b1;
         end
         CLS_STORE: begin
            sw[SW_6] = 1'b1;
            is_mem   = 1'b1;
         end
         default: begin  // CLS_LOAD
            is_mem = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/data_select_sequencer.sv
// ---------------------------------------------------------------------------
// data_select_sequencer
// Multi-cycle instruction sequencer: accepts an instruction in IDLE, steps
// it through DECODE, EXEC, optional MEM and WB, and holds the datapath mux
// selects stable for the whole instruction. HLT parks the block in HALT.
//   clk       in   1      clock, rising edge
//   rst_n     in   1      synchronous active-low reset
//   op        in   OP_W   instruction word, sampled on accept
//   op_valid  in   1      op is valid
//   op_ready  out  1      can accept (IDLE only)
//   mem_wait  in   1      holds the MEM phase while high
//   resume    in   1      leave HALT
//   sw        out  N_SW   registered mux selects
//   phase     out  4      one-hot {WB,MEM,EXEC,DECODE}
//   done      out  1      high during the WB cycle
//   halted    out  1      high in HALT
//   retired   out  CNT_W  completed WB count (wraps)
// ---------------------------------------------------------------------------
module data_select_sequencer
   import data_select_sequencer_pkg::*;
#(
   parameter int OP_W  = 16,
   parameter int N_SW  = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OP_W-1:0]  op,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic             mem_wait,
   input  logic             resume,
   output logic [N_SW-1:0]  sw,
   output logic [3:0]       phase,
   output logic             done,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   logic [2:0]       state_reg, state_next;
   logic [N_SW-1:0]  sw_reg;
   logic             is_mem_reg;
   logic [3:0]       phase_reg;
   logic             done_reg;
   logic             halted_reg;
   logic [CNT_W-1:0] retired_reg;

   logic [N_SW-1:0]  dec_sw;
   logic             dec_is_hlt;
   logic             dec_is_mem;
   logic             accept;

   data_select_sequencer_sw_decode #(
      .OP_W (OP_W),
      .N_SW (N_SW)
   ) u_sw_decode (
      .op     (op),
      .sw     (dec_sw),
      .is_hlt (dec_is_hlt),
      .is_mem (dec_is_mem)
   );

   assign accept = (state_reg == ST_IDLE) && op_valid;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (op_valid) state_next = dec_is_hlt ? ST_HALT : ST_DECODE;
         ST_DECODE: state_next = ST_EXEC;
         ST_EXEC:   state_next = is_mem_reg ? ST_MEM : ST_WB;
         ST_MEM:    if (!mem_wait) state_next = ST_WB;
         ST_WB:     state_next = ST_IDLE;
         ST_HALT:   if (resume) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Phase/done/halted are registered from the next state so they line up
   // exactly with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         sw_reg      <= '0;
         is_mem_reg  <= 1'b0;
         phase_reg   <= 4'b0000;
         done_reg    <= 1'b0;
         halted_reg  <= 1'b0;
         retired_reg <= '0;
      end else begin
         state_reg  <= state_next;
         phase_reg  <= phase_of(state_next);
         done_reg   <= (state_next == ST_WB);
         halted_reg <= (state_next == ST_HALT);

         // Selects are captured once per instruction; HLT decodes to all-zero.
         if (accept) begin
            sw_reg     <= dec_sw;
            is_mem_reg <= dec_is_mem;
         end else if (state_reg == ST_WB) begin
            sw_reg     <= '0;
         end

         if (state_reg == ST_WB) retired_reg <= retired_reg + CNT_W'(1);
      end
   end

   assign op_ready = (state_reg == ST_IDLE);
   assign sw       = sw_reg;
   assign phase    = phase_reg;
   assign done     = done_reg;
   assign halted   = halted_reg;
   assign retired  = retired_reg;

endmodule
